// File: rtl/pio_write_arbiter.sv
// Round-robin arbiter that lets several hardware requesters share one
// zero-wait-state Avalon-MM output PIO (data register at address 0).
// Each granted request becomes one single-cycle write. A shadow copy of
// the PIO value lets repeated identical values be acknowledged without
// touching the bus.
module pio_write_arbiter #(
  parameter int NUM_REQ   = 3,  // number of requesters (2..8)
  parameter int MIN_GAP   = 1,  // idle cycles forced between writes (0..15)
  parameter int SKIP_SAME = 1   // 1: acknowledge same-value requests without a write
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic [1:0]           pio_address,
  output logic                 pio_chipselect,
  output logic                 pio_write_n,
  output logic [31:0]          pio_writedata,
  output logic [7:0]           shadow_q,
  output logic [NUM_REQ-1:0]   last_grant,
  output logic [15:0]          write_count,
  output logic                 busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [3:0] GAP_LOAD = (MIN_GAP > 0) ? 4'(MIN_GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_win;
  logic [7:0]         r_data;
  logic               r_do_write;
  logic [3:0]         r_gap_cnt;
  logic [NUM_REQ-1:0] r_ack;
  logic               r_cs;
  logic               r_wn;
  logic [31:0]        r_wdata;
  logic [7:0]         r_shadow;
  logic               r_shadow_valid;
  logic [NUM_REQ-1:0] r_last_grant;
  logic [15:0]        r_write_count;

  logic               w_found;
  logic [IDX_W-1:0]   w_win_idx;
  logic [7:0]         w_sel_data;
  logic               w_skip;

  // Pick the first pending requester at or above the pointer, wrapping around.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned (which would infer a latch).
    w_found   = 1'b0;
    w_win_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && req_valid[(int'(r_ptr) + k) % NUM_REQ]) begin
        w_found   = 1'b1;
        w_win_idx = IDX_W'((int'(r_ptr) + k) % NUM_REQ);
      end
    end
    w_sel_data = req_data[8*w_win_idx +: 8];
    w_skip     = (SKIP_SAME != 0) && r_shadow_valid && (w_sel_data == r_shadow);
  end

  // Arbitration FSM with registered bus strobes, ack, shadow and counter.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments only, and the
    // asynchronous reset clears every register so a strobe in flight drops
    // the moment reset_n falls.
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_ptr          <= '0;
      r_win          <= '0;
      r_data         <= 8'h00;
      r_do_write     <= 1'b0;
      r_gap_cnt      <= 4'd0;
      r_ack          <= '0;
      r_cs           <= 1'b0;
      r_wn           <= 1'b1;
      r_wdata        <= 32'h0;
      r_shadow       <= 8'h00;
      r_shadow_valid <= 1'b0;
      r_last_grant   <= '0;
      r_write_count  <= 16'h0000;
    end else begin
      // Strobes and ack are single-cycle pulses unless re-armed below.
      r_ack <= '0;
      r_cs  <= 1'b0;
      r_wn  <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            // The request is committed here; later changes on req_* are ignored.
            r_win      <= w_win_idx;
            r_data     <= w_sel_data;
            r_do_write <= !w_skip;
            r_ack      <= NUM_REQ'(1) << w_win_idx;
            r_cs       <= !w_skip;
            r_wn       <= w_skip;
            if (!w_skip) r_wdata <= {24'h0, w_sel_data};
            r_state    <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_last_grant <= NUM_REQ'(1) << r_win;
          r_ptr        <= (r_win == IDX_W'(NUM_REQ - 1)) ? '0 : r_win + 1'b1;
          if (r_do_write) begin
            r_shadow       <= r_data;
            r_shadow_valid <= 1'b1;
            r_write_count  <= r_write_count + 16'd1;
          end
          if (MIN_GAP > 0) begin
            r_gap_cnt <= GAP_LOAD;
            r_state   <= S_GAP;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_GAP: begin
          if (r_gap_cnt == 4'd0) r_state <= S_IDLE;
          else                   r_gap_cnt <= r_gap_cnt - 4'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ack        = r_ack;
  assign pio_address    = 2'b00;
  assign pio_chipselect = r_cs;
  assign pio_write_n    = r_wn;
  assign pio_writedata  = r_wdata;
  assign shadow_q       = r_shadow;
  assign last_grant     = r_last_grant;
  assign write_count    = r_write_count;
  assign busy           = (r_state != S_IDLE);

endmodule

// File: tb/tb_pio_write_arbiter.sv
// Directed bench for pio_write_arbiter (NUM_REQ=3, MIN_GAP=1, SKIP_SAME=1).
// Expected grants are queued when requests are driven; a negedge monitor
// pops and compares them whenever the DUT acks or strobes the bus.
module tb_pio_write_arbiter;

  localparam int NUM_REQ = 3;
  localparam int MIN_GAP = 1;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ack;
  logic [1:0]           pio_address;
  logic                 pio_chipselect;
  logic                 pio_write_n;
  logic [31:0]          pio_writedata;
  logic [7:0]           shadow_q;
  logic [NUM_REQ-1:0]   last_grant;
  logic [15:0]          write_count;
  logic                 busy;

  pio_write_arbiter #(.NUM_REQ(NUM_REQ), .MIN_GAP(MIN_GAP), .SKIP_SAME(1)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ack        (req_ack),
    .pio_address    (pio_address),
    .pio_chipselect (pio_chipselect),
    .pio_write_n    (pio_write_n),
    .pio_writedata  (pio_writedata),
    .shadow_q       (shadow_q),
    .last_grant     (last_grant),
    .write_count    (write_count),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] data;
    logic       wr;
  } exp_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic push(input int idx, input logic [7:0] data, input logic wr);
    exp_t e;
    e.idx  = 2'(idx);
    e.data = data;
    e.wr   = wr;
    sb_q.push_back(e);
  endtask

  // Waits (bounded) for an ack, returns it sampled at a negedge.
  task automatic wait_ack(input string tag, input int bound, output logic [NUM_REQ-1:0] got);
    got = '0;
    for (int i = 0; i < bound && got == '0; i++) begin
      @(negedge clk);
      got = req_ack;
    end
    n_total = n_total + 1;
    assert (got !== '0) n_pass = n_pass + 1;
    else $error("FAIL %s: no ack within %0d cycles, observed 0x%0h expected nonzero", tag, bound, got);
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Scoreboard monitor: every ack/strobe must match the next queued grant.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && (req_ack !== '0 || pio_chipselect !== 1'b0 || pio_write_n !== 1'b1)) begin
      if (sb_q.size() == 0) begin
        check("unexpected_event", {28'h0, pio_chipselect, req_ack}, 32'h0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_ack", 32'(req_ack), 32'(3'b001 << e.idx));
        check("sb_cs", 32'(pio_chipselect), 32'(e.wr));
        check("sb_write_n", 32'(pio_write_n), 32'(!e.wr));
        check("sb_addr", 32'(pio_address), 32'h0);
        if (e.wr) check("sb_wdata", pio_writedata, {24'h0, e.data});
      end
    end
  end

  initial begin
    logic [NUM_REQ-1:0] got;
    int t_ack[3];

    req_data = '0;
    do_reset();

    // Reset state
    check("rst_cs", 32'(pio_chipselect), 32'h0);
    check("rst_write_n", 32'(pio_write_n), 32'h1);
    check("rst_addr", 32'(pio_address), 32'h0);
    check("rst_wdata", pio_writedata, 32'h0);
    check("rst_ack", 32'(req_ack), 32'h0);
    check("rst_shadow", 32'(shadow_q), 32'h0);
    check("rst_last_grant", 32'(last_grant), 32'h0);
    check("rst_count", 32'(write_count), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);

    // Single request from requester 0
    req_data  = 24'h00005A;
    req_valid = 3'b001;
    push(0, 8'h5A, 1'b1);
    wait_ack("single_ack", 10, got);
    req_valid = '0;
    check("single_grant", 32'(got), 32'h1);
    @(negedge clk);
    check("single_shadow", 32'(shadow_q), 32'h5A);
    check("single_count", 32'(write_count), 32'h1);
    check("single_last_grant", 32'(last_grant), 32'h1);
    check("single_busy_gap", 32'(busy), 32'h1);
    @(negedge clk);
    check("single_busy_idle", 32'(busy), 32'h0);

    // Three simultaneous requests from a fresh reset
    do_reset();
    req_data  = 24'h332211;
    req_valid = 3'b111;
    push(0, 8'h11, 1'b1);
    push(1, 8'h22, 1'b1);
    push(2, 8'h33, 1'b1);
    for (int n = 0; n < 3; n++) begin
      wait_ack("multi_ack", 20, got);
      t_ack[n]  = cyc;
      req_valid = req_valid & ~got;
    end
    check("multi_spacing01", 32'(t_ack[1] - t_ack[0]), 32'(2 + MIN_GAP));
    check("multi_spacing12", 32'(t_ack[2] - t_ack[1]), 32'(2 + MIN_GAP));
    @(negedge clk);
    check("multi_count", 32'(write_count), 32'h3);
    check("multi_shadow", 32'(shadow_q), 32'h33);

    // Fairness: req0 and req2 held permanently, pointer now at 0
    repeat (2) @(negedge clk);
    req_data  = 24'h410040;
    req_valid = 3'b101;
    for (int n = 0; n < 8; n++) begin
      if (n % 2 == 0) push(0, 8'h40, 1'b1);
      else            push(2, 8'h41, 1'b1);
    end
    for (int n = 0; n < 8; n++) begin
      wait_ack("fair_ack", 20, got);
      check("fair_alternate", 32'(got), (n % 2 == 0) ? 32'h1 : 32'h4);
    end
    req_valid = '0;
    @(negedge clk);
    check("fair_count", 32'(write_count), 32'd11);

    // Same-value skip
    do_reset();
    req_data  = 24'h00A500;
    req_valid = 3'b010;
    push(1, 8'hA5, 1'b1);
    wait_ack("skip_first_ack", 10, got);
    req_valid = '0;
    repeat (3) @(negedge clk);
    req_valid = 3'b010;
    push(1, 8'hA5, 1'b0);
    wait_ack("skip_same_ack", 10, got);
    req_valid = '0;
    @(negedge clk);
    check("skip_same_count", 32'(write_count), 32'h1);
    check("skip_same_shadow", 32'(shadow_q), 32'hA5);
    repeat (2) @(negedge clk);
    req_data  = 24'h00A600;
    req_valid = 3'b010;
    push(1, 8'hA6, 1'b1);
    wait_ack("skip_new_ack", 10, got);
    req_valid = '0;
    @(negedge clk);
    check("skip_new_count", 32'(write_count), 32'h2);
    check("skip_new_shadow", 32'(shadow_q), 32'hA6);

    // Reset asserted in the middle of the WRITE cycle
    repeat (3) @(negedge clk);
    req_data  = 24'h000077;
    req_valid = 3'b001;
    push(0, 8'h77, 1'b1);
    push(0, 8'h77, 1'b1);
    wait_ack("rstw_ack", 10, got);
    #2 reset_n = 1'b0;
    #1;
    check("rstw_cs", 32'(pio_chipselect), 32'h0);
    check("rstw_write_n", 32'(pio_write_n), 32'h1);
    check("rstw_ack_low", 32'(req_ack), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rstw_shadow", 32'(shadow_q), 32'h0);
    check("rstw_count", 32'(write_count), 32'h0);
    check("rstw_busy", 32'(busy), 32'h0);
    wait_ack("rstw_reserve_ack", 10, got);
    req_valid = '0;
    @(negedge clk);
    check("rstw_reserve_count", 32'(write_count), 32'h1);
    check("rstw_reserve_shadow", 32'(shadow_q), 32'h77);

    // Counter wrap 0xFFFF -> 0
    repeat (3) @(negedge clk);
    force dut.r_write_count = 16'hFFFF;
    @(negedge clk);
    release dut.r_write_count;
    @(negedge clk);
    check("wrap_preload", 32'(write_count), 32'hFFFF);
    req_data  = 24'h000078;
    req_valid = 3'b001;
    push(0, 8'h78, 1'b1);
    wait_ack("wrap_ack", 10, got);
    req_valid = '0;
    @(negedge clk);
    check("wrap_count", 32'(write_count), 32'h0);
    check("wrap_shadow", 32'(shadow_q), 32'h78);

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
